// File: rtl/fwd_hazard_unit_pkg.sv
// hazard_pkg: shared types and defaults for the forwarding/hazard unit.
//  fwd_sel_e    per-operand ALU bypass select (2'b11 is never produced)
//  DEF_*        default sizing used by the interface and the top module
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_MAX_LAT  = 4;
  localparam int DEF_NUM_SRC  = 2;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: pipeline-side bundle for the forwarding/hazard unit.
//  issue_*      instruction being issued into EX (valid, write enable, dest, latency)
//  ex_src*      EX source registers and per-operand read valids
//  exmem_*      EX/MEM writeback enable/destination
//  memwb_*      MEM/WB writeback enable/destination
//  oForward     per-operand bypass select, operand i at [i*2 +: 2]
//  stall        hold IF/ID and bubble EX
//  issue_ack    instruction accepted this cycle
// Modports: master = pipeline side, slave = hazard unit side.
interface fwd_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  NUM_SRC  = DEF_NUM_SRC,
  parameter int  MAX_LAT  = DEF_MAX_LAT,
  localparam int REG_W    = $clog2(NUM_REGS),
  localparam int LAT_W    = $clog2(MAX_LAT + 1)
) ();

  logic                     issue_valid;
  logic                     issue_wen;
  logic [REG_W-1:0]         issue_dest;
  logic [LAT_W-1:0]         issue_lat;
  logic [NUM_SRC*REG_W-1:0] ex_src;
  logic [NUM_SRC-1:0]       ex_src_vld;
  logic                     exmem_wen;
  logic [REG_W-1:0]         exmem_dest;
  logic                     memwb_wen;
  logic [REG_W-1:0]         memwb_dest;
  logic [NUM_SRC*2-1:0]     oForward;
  logic                     stall;
  logic                     issue_ack;

  modport master (
    output issue_valid, issue_wen, issue_dest, issue_lat,
    output ex_src, ex_src_vld, exmem_wen, exmem_dest, memwb_wen, memwb_dest,
    input  oForward, stall, issue_ack
  );

  modport slave (
    input  issue_valid, issue_wen, issue_dest, issue_lat,
    input  ex_src, ex_src_vld, exmem_wen, exmem_dest, memwb_wen, memwb_dest,
    output oForward, stall, issue_ack
  );

endinterface

// File: rtl/fwd_hazard_unit_sb_counter.sv
// sb_counter: one scoreboard entry; counts remaining cycles until the
// register's in-flight result becomes forwardable.
//  clk, rst_n   clock, async active-low reset
//  clear        synchronous clear (pipeline flush), beats load
//  load         start a new countdown from load_val (youngest writer wins)
//  load_val     initial count (already latency-1)
//  busy         count is nonzero: readers of this register must stall
module sb_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  // Clear beats load beats decrement; the decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: per-operand forwarding select plus a per-register
// scoreboard of multi-cycle writes that stalls dependent issue.
//  clk, rst_n    pipeline clock, async active-low reset
//  flush         clears the whole scoreboard at the next edge
//  bus           fwd_hazard_unit_if.slave (issue, EX sources, EX/MEM, MEM/WB,
//                oForward, stall, issue_ack)
//  stall_cycles, fwd_events  only when HAZARD_STATS_EN is defined:
//                saturating counts of stall cycles and forwarding cycles
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  NUM_SRC  = DEF_NUM_SRC,
  parameter int  MAX_LAT  = DEF_MAX_LAT,
  localparam int REG_W    = $clog2(NUM_REGS),
  localparam int LAT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  fwd_hazard_unit_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      fwd_events
`endif
);

  logic [NUM_REGS-1:0]  busy;
  logic [LAT_W-1:0]     load_val;
  logic                 do_load;
  logic                 src_hazard;
  logic [NUM_SRC*2-1:0] fwd;

  // Latency 0 behaves as 1 and anything above MAX_LAT is clamped; the
  // counter holds latency-1 because the issue edge itself is one cycle.
  always_comb begin
    load_val = '0;
    if (bus.issue_lat == '0) begin
      load_val = '0;
    end else if (bus.issue_lat > LAT_W'(MAX_LAT)) begin
      load_val = LAT_W'(MAX_LAT - 1);
    end else begin
      load_val = bus.issue_lat - LAT_W'(1);
    end
  end

  assign do_load = bus.issue_ack & bus.issue_wen & (bus.issue_dest != '0);

  // r0 never has a pending write.
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    sb_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flush),
      .load     (do_load && (bus.issue_dest == REG_W'(r))),
      .load_val (load_val),
      .busy     (busy[r])
    );
  end

  // EX/MEM is the younger producer, so it is checked first.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.ex_src_vld[i] && (bus.ex_src[i*REG_W +: REG_W] != '0)) begin
        if (bus.exmem_wen && (bus.exmem_dest == bus.ex_src[i*REG_W +: REG_W])) begin
          fwd[i*2 +: 2] = FWD_EXMEM;
        end else if (bus.memwb_wen && (bus.memwb_dest == bus.ex_src[i*REG_W +: REG_W])) begin
          fwd[i*2 +: 2] = FWD_MEMWB;
        end
      end
    end
  end

  // Stall uses the pre-edge counts, so it drops the cycle a count hits zero.
  always_comb begin
    src_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.ex_src_vld[i] && busy[bus.ex_src[i*REG_W +: REG_W]]) begin
        src_hazard = 1'b1;
      end
    end
  end

  assign bus.oForward  = fwd;
  assign bus.stall     = bus.issue_valid & src_hazard;
  assign bus.issue_ack = bus.issue_valid & ~src_hazard;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_events_q, fwd_events_d;

  // Saturating event counters; flush deliberately leaves them alone.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fwd_events_d   = fwd_events_q;
    if (bus.stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if ((fwd != '0) && !bus.stall && (fwd_events_q != '1)) begin
      fwd_events_d = fwd_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule
